// File: rtl/decoder64b66b_sync_pkg.sv
// Shared definitions for the 64b/66b block-sync decoder: sync header codes,
// lock FSM state encoding and a header classification helper.
package pkg_64b66b;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_TEST   = 2'd1,
    ST_SLIP   = 2'd2,
    ST_LOCKED = 2'd3
  } lock_state_e;

  // Only the two transition patterns are legal sync headers.
  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/descrambler64b.sv
// Self-synchronising x^58+x^39+1 descrambler, 64 bits per enabled cycle.
// Bit 0 of din is the earliest bit on the line.
module descrambler64b (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [63:0] din,
  output logic [63:0] dout
);

  logic [57:0] state_q;
  logic [57:0] state_d;

  // Walk the word LSB first: each output bit uses the taps of the running
  // state, and the state then absorbs the received (scrambled) bit.
  always_comb begin
    state_d = state_q;
    dout    = '0;
    for (int i = 0; i < 64; i++) begin
      dout[i] = din[i] ^ state_d[38] ^ state_d[57];
      state_d = {state_d[56:0], din[i]};
    end
  end

  // State register advances only on words that were actually taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
    end else if (en) begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/decoder64b66b_sync.sv
// 64b/66b receive path: sync-header lock FSM with slip requests toward the
// gearbox, optional descrambling, and a one-deep registered output stage.
//
// Handshake: a word moves on any cycle where tvalid and tready are both high.
// The source must hold tvalid/tdata until taken; the output holds
// m_axis_tvalid/ttype/tdata steady while m_axis_tready is low.
module decoder64b66b_sync
  import pkg_64b66b::*;
#(
  parameter int SH_CNT_MAX = 64,
  parameter int SH_INV_MAX = 16,
  parameter int SLIP_WAIT  = 4,
  parameter int DESCRAMBLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [65:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [1:0]  m_axis_ttype,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        o_block_lock,
  output logic        o_slip,
  output lock_state_e dbg_state
);

  localparam int CW = $clog2(SH_CNT_MAX + 1);
  localparam int WW = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SH_CNT_MAX);
  localparam logic [CW-1:0] INV_MAX   = CW'(SH_INV_MAX);
  localparam logic [WW-1:0] WAIT_LAST = WW'((SLIP_WAIT > 0) ? SLIP_WAIT - 1 : 0);

  lock_state_e   state;
  logic [CW-1:0] sh_cnt;
  logic [CW-1:0] sh_inv_cnt;
  logic [WW-1:0] slip_cnt;

  logic          accept;
  logic [1:0]    hdr;
  logic          hdr_ok;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] inv_inc;
  logic [63:0]   dscr_out;
  logic [63:0]   payload;

  // Input is taken whenever the output register is free or draining; held
  // high through reset so upstream never sees a stall there.
  assign s_axis_tready = reset || !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign hdr           = s_axis_tdata[1:0];
  assign hdr_ok        = sh_is_valid(hdr);
  assign cnt_inc       = sh_cnt + CW'(1);
  assign inv_inc       = sh_inv_cnt + CW'(hdr_ok ? 0 : 1);
  assign payload       = (DESCRAMBLE != 0) ? dscr_out : s_axis_tdata[65:2];
  assign dbg_state     = state;

  // Descrambler sees every accepted word so it stays synchronised while unlocked.
  descrambler64b u_descrambler (
    .clk   (clk),
    .reset (reset),
    .en    (accept && (DESCRAMBLE != 0)),
    .din   (s_axis_tdata[65:2]),
    .dout  (dscr_out)
  );

  // Lock FSM, header counters and the registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_INIT;
      sh_cnt        <= '0;
      sh_inv_cnt    <= '0;
      slip_cnt      <= '0;
      o_block_lock  <= 1'b0;
      o_slip        <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_ttype  <= '0;
      m_axis_tdata  <= '0;
    end else begin
      o_slip <= 1'b0;
      if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      case (state)
        ST_INIT: begin
          sh_cnt     <= '0;
          sh_inv_cnt <= '0;
          slip_cnt   <= '0;
          state      <= ST_TEST;
        end

        ST_TEST: begin
          if (accept) begin
            if (!hdr_ok) begin
              state    <= ST_SLIP;
              o_slip   <= 1'b1;
              slip_cnt <= '0;
            end else if (cnt_inc == CNT_MAX) begin
              state        <= ST_LOCKED;
              o_block_lock <= 1'b1;
              sh_cnt       <= '0;
              sh_inv_cnt   <= '0;
            end else begin
              sh_cnt <= cnt_inc;
            end
          end
        end

        ST_SLIP: begin
          if (SLIP_WAIT == 0) begin
            state <= ST_INIT;
          end else if (accept) begin
            if (slip_cnt == WAIT_LAST) begin
              state <= ST_INIT;
            end else begin
              slip_cnt <= slip_cnt + WW'(1);
            end
          end
        end

        ST_LOCKED: begin
          if (accept) begin
            if (inv_inc == INV_MAX) begin
              // Too many bad headers: the triggering word is dropped.
              state        <= ST_SLIP;
              o_block_lock <= 1'b0;
              o_slip       <= 1'b1;
              slip_cnt     <= '0;
              sh_cnt       <= '0;
              sh_inv_cnt   <= '0;
            end else begin
              m_axis_tvalid <= 1'b1;
              m_axis_ttype  <= hdr;
              m_axis_tdata  <= payload;
              if (cnt_inc == CNT_MAX) begin
                sh_cnt     <= '0;
                sh_inv_cnt <= '0;
              end else begin
                sh_cnt     <= cnt_inc;
                sh_inv_cnt <= inv_inc;
              end
            end
          end
        end

        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder64b66b_sync.sv
// Directed bench for decoder64b66b_sync: lock acquisition, slip on
// misalignment, invalid-header thresholds, backpressure, bypass mode and
// reset while stalled.
module tb_decoder64b66b_sync;
  import pkg_64b66b::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 1: default parameters ----------------
  logic [65:0] s_tdata  = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [1:0]  m_ttype;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        lock;
  logic        slip;
  lock_state_e st;

  decoder64b66b_sync dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_ttype  (m_ttype),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .o_block_lock  (lock),
    .o_slip        (slip),
    .dbg_state     (st)
  );

  // ---------------- DUT 2: descrambler bypass, short windows ----------------
  logic [65:0] s2_tdata  = '0;
  logic        s2_tvalid = 1'b0;
  logic        s2_tready;
  logic [1:0]  m2_ttype;
  logic [63:0] m2_tdata;
  logic        m2_tvalid;
  logic        m2_tready = 1'b1;
  logic        lock2;
  logic        slip2;
  lock_state_e st2;

  decoder64b66b_sync #(
    .SH_CNT_MAX (4),
    .SH_INV_MAX (2),
    .SLIP_WAIT  (2),
    .DESCRAMBLE (0)
  ) dut2 (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s2_tdata),
    .s_axis_tvalid (s2_tvalid),
    .s_axis_tready (s2_tready),
    .m_axis_ttype  (m2_ttype),
    .m_axis_tdata  (m2_tdata),
    .m_axis_tvalid (m2_tvalid),
    .m_axis_tready (m2_tready),
    .o_block_lock  (lock2),
    .o_slip        (slip2),
    .dbg_state     (st2)
  );

  // ---------------- scoreboard state ----------------
  logic [65:0] exp_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  bit          rand_rdy = 1'b0;
  logic [57:0] scr_s = 58'h2A5_1234_5678_9ABC;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Line-side scrambler: the transmitter's view, feeding back its own output.
  task automatic scramble(input logic [63:0] p, output logic [63:0] o);
    logic b;
    for (int i = 0; i < 64; i++) begin
      b       = p[i] ^ scr_s[38] ^ scr_s[57];
      o[i]    = b;
      scr_s   = {scr_s[56:0], b};
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Present a raw line word and wait (bounded) until it is taken.
  task automatic send(input logic [1:0] h, input logic [63:0] p);
    int n;
    n        = 0;
    s_tdata  = {p, h};
    s_tvalid = 1'b1;
    if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
    #1;
    while (!s_tready && n < 200) begin
      @(negedge clk);
      #1;
      if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
      #1;
      n++;
    end
    if (n >= 200) check("send_timeout", 66'(s_tready), 66'(1));
    @(negedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_plain(input logic [1:0] h, input logic [63:0] plain, input bit expect_out);
    logic [63:0] o;
    scramble(plain, o);
    if (expect_out) exp_q.push_back({plain, h});
    send(h, o);
  endtask

  task automatic send2(input logic [1:0] h, input logic [63:0] p);
    s2_tdata  = {p, h};
    s2_tvalid = 1'b1;
    #1;
    check("dut2_ready", 66'(s2_tready), 66'(1));
    @(negedge clk);
    #1;
    s2_tvalid = 1'b0;
  endtask

  // ---------------- output monitor ----------------
  logic        prev_stall = 1'b0;
  logic [65:0] prev_out   = '0;
  always begin
    @(negedge clk);
    #3;
    if (!reset) begin
      if (prev_stall) begin
        check("stall_valid", 66'(m_tvalid), 66'(1));
        check("stall_data", {m_tdata, m_ttype}, prev_out);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $error("FAIL unexpected_out got=%h exp=none", {m_tdata, m_ttype});
        end else begin
          check("out_word", {m_tdata, m_ttype}, exp_q.pop_front());
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tdata, m_ttype};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [65:0] cur;
    logic [65:0] nxt;
    logic [65:0] w;
    logic [63:0] o;
    logic [1:0]  h;
    logic        seen;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_tready", 66'(s_tready), 66'(1));
    check("rst_tvalid", 66'(m_tvalid), 66'(0));
    check("rst_tdata", 66'(m_tdata), 66'(0));
    check("rst_ttype", 66'(m_ttype), 66'(0));
    check("rst_lock", 66'(lock), 66'(0));
    check("rst_slip", 66'(slip), 66'(0));
    check("rst_state", 66'(st), 66'(ST_INIT));
    reset = 1'b0;
    idle(1);
    check("init_to_test", 66'(st), 66'(ST_TEST));

    // Lock on 64 scrambled idle control words; none of them are forwarded
    for (int k = 1; k <= 64; k++) begin
      if (k == 64) check("lock_before_64", 66'(lock), 66'(0));
      send_plain(SH_CTRL, 64'h1E, 1'b0);
    end
    check("lock_after_64", 66'(lock), 66'(1));
    check("locked_state", 66'(st), 66'(ST_LOCKED));
    check("no_out_while_locking", 66'(m_tvalid), 66'(0));

    // Window with 15 invalid headers: lock held, all forwarded
    for (int k = 1; k <= 64; k++) begin
      if (k == 1)
        send_plain(SH_CTRL, 64'h1E, 1'b1);
      else if (k % 4 == 0 && k <= 60)
        send_plain((k % 8 == 0) ? 2'b11 : 2'b00, {32'hBAD0_0000, 32'(k)}, 1'b1);
      else
        send_plain(SH_DATA, {32'h0123_4567, 32'(k)}, 1'b1);
    end
    check("lock_15_invalid", 66'(lock), 66'(1));
    idle(2);
    check("drain_window1", 66'(exp_q.size()), 66'(0));

    // Window with 16 invalid headers: 15 forwarded, 16th drops lock
    for (int k = 1; k <= 16; k++)
      send_plain((k % 2 == 1) ? 2'b11 : 2'b00, {32'h1600_0000, 32'(k)}, k <= 15);
    check("lock_16_invalid", 66'(lock), 66'(0));
    check("slip_on_loss", 66'(slip), 66'(1));
    check("slip_state", 66'(st), 66'(ST_SLIP));
    idle(1);
    check("slip_one_cycle", 66'(slip), 66'(0));
    idle(1);
    check("drain_window2", 66'(exp_q.size()), 66'(0));

    // SLIP_WAIT words dropped, then INIT, then TEST
    for (int k = 0; k < 4; k++) send_plain(SH_DATA, 64'(k), 1'b0);
    check("slip_wait_to_init", 66'(st), 66'(ST_INIT));
    idle(1);
    check("reinit_test", 66'(st), 66'(ST_TEST));

    // Stream shifted by one bit until the header check slips
    scramble(64'h1E, o);
    cur  = {o, SH_CTRL};
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      scramble(64'h1E, o);
      nxt = {o, SH_CTRL};
      w   = {nxt[0], cur[65:1]};
      send(w[1:0], w[65:2]);
      seen = slip;
      cur  = nxt;
    end
    check("misalign_slip", 66'(seen), 66'(1));
    idle(1);
    check("misalign_slip_pulse", 66'(slip), 66'(0));
    check("misalign_no_lock", 66'(lock), 66'(0));
    for (int k = 0; k < 4; k++) send_plain(SH_DATA, 64'(k), 1'b0);
    idle(1);

    // Realigned stream relocks after 64 words
    for (int k = 1; k <= 64; k++) begin
      if (k == 64) check("relock_before_64", 66'(lock), 66'(0));
      send_plain(SH_DATA, {32'hCAFE_0000, 32'(k)}, 1'b0);
    end
    check("relock_after_64", 66'(lock), 66'(1));
    send_plain(SH_DATA, 64'hDEAD_BEEF_0000_0001, 1'b1);
    idle(2);
    check("drain_relock", 66'(exp_q.size()), 66'(0));

    // Random backpressure on the output
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k % 13 == 5)      h = (k % 2 == 1) ? 2'b11 : 2'b00;
      else if (k % 3 == 0)  h = SH_CTRL;
      else                  h = SH_DATA;
      send_plain(h, {$urandom, $urandom}, 1'b1);
    end
    rand_rdy = 1'b0;
    m_tready = 1'b1;
    idle(3);
    check("drain_backpressure", 66'(exp_q.size()), 66'(0));
    check("lock_after_backpressure", 66'(lock), 66'(1));

    // Reset while the output word is stalled
    m_tready = 1'b0;
    send_plain(SH_DATA, 64'h5555_AAAA_5555_AAAA, 1'b0);
    idle(1);
    check("stalled_valid", 66'(m_tvalid), 66'(1));
    reset    = 1'b1;
    s_tdata  = {64'hFFFF_0000_FFFF_0000, SH_DATA};
    s_tvalid = 1'b1;
    #1;
    check("tready_in_reset", 66'(s_tready), 66'(1));
    @(negedge clk);
    #1;
    reset    = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    check("mid_rst_tvalid", 66'(m_tvalid), 66'(0));
    check("mid_rst_tdata", 66'(m_tdata), 66'(0));
    check("mid_rst_ttype", 66'(m_ttype), 66'(0));
    check("mid_rst_lock", 66'(lock), 66'(0));
    check("mid_rst_slip", 66'(slip), 66'(0));
    check("mid_rst_state", 66'(st), 66'(ST_INIT));

    // Bypass instance: payload passes through unchanged
    idle(1);
    for (int k = 0; k < 4; k++) send2(SH_DATA, 64'(k));
    check("dut2_lock", 66'(lock2), 66'(1));
    check("dut2_no_out_yet", 66'(m2_tvalid), 66'(0));
    send2(SH_DATA, 64'h0123_4567_89AB_CDEF);
    check("dut2_valid", 66'(m2_tvalid), 66'(1));
    check("dut2_word", {m2_tdata, m2_ttype}, {64'h0123_4567_89AB_CDEF, 2'b01});
    send2(2'b11, 64'hFEDC_BA98_7654_3210);
    check("dut2_invalid_fwd", {m2_tdata, m2_ttype}, {64'hFEDC_BA98_7654_3210, 2'b11});
    check("dut2_lock_held", 66'(lock2), 66'(1));

    idle(2);
    check("final_drain", 66'(exp_q.size()), 66'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder64b66b_sync.md
DECODER64B66B_SYNC -- requirements
Module: decoder64b66b_sync

Interface
REQ-001 SHALL have parameter SH_CNT_MAX, default 64, meaning accepted words per sync-header test window.
REQ-002 SHALL have parameter SH_INV_MAX, default 16, meaning invalid headers per window that drop lock.
REQ-003 SHALL have parameter SLIP_WAIT, default 4, meaning accepted words ignored after a slip pulse.
REQ-004 SHALL have parameter DESCRAMBLE, default 1, meaning 1 enables the x^58+x^39+1 descrambler and 0 bypasses it.
REQ-005 SHALL have one clock and a synchronous, active-high reset: ports clk and reset.
REQ-006 SHALL have ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- s_axis_tdata  in  66  bits [1:0] sync header, [65:2] payload, bit 2 first on line
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_ttype  out  2  sync header of output word
- m_axis_tdata  out  64  descrambled payload
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- o_block_lock  out  1  block lock achieved
- o_slip  out  1  one-cycle request to upstream gearbox to shift one bit

Function
REQ-007 SHALL define a transfer as a cycle with tvalid and tready both high.
REQ-008 SHALL drive s_axis_tready = !m_axis_tvalid || m_axis_tready in every state, locked or not.
REQ-009 SHALL register each accepted word to the output one cycle after acceptance, only while o_block_lock is 1 after that word's lock update.
REQ-010 SHALL consume and drop words accepted while unlocked: no output.
REQ-011 SHALL hold m_axis_tvalid/ttype/tdata stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-012 SHALL classify a header as valid if 2'b01 (data) or 2'b10 (control); 2'b00/2'b11 are invalid and, when locked, are forwarded unchanged on m_axis_ttype.
REQ-013 SHALL update the descrambler on every accepted word, locked or not. Per payload bit i (LSB first): out = in ^ s[38] ^ s[57]; the state shifts in the received bit. State is 58 bits.
REQ-014 SHALL pass the payload unchanged when DESCRAMBLE=0; the descrambler state is then unused.
REQ-015 SHALL implement the lock FSM with states INIT, TEST, SLIP, LOCKED, which advance only on accepted words, except for the INIT exit.
REQ-016 INIT: SHALL clear sh_cnt and sh_inv_cnt and go to TEST on the next cycle.
REQ-017 TEST: on a valid header, SHALL increment sh_cnt; on reaching SH_CNT_MAX, SHALL go to LOCKED and clear the counters. On an invalid header, SHALL go to SLIP.
REQ-018 SLIP: SHALL pulse o_slip for exactly one cycle on entry, then discard SLIP_WAIT accepted words, then go to INIT.
REQ-019 LOCKED: SHALL increment sh_cnt on every accepted word and sh_inv_cnt on each invalid header.
- sh_inv_cnt reaching SH_INV_MAX: SHALL drop o_block_lock and go to SLIP. The triggering word is not forwarded.
- sh_cnt reaching SH_CNT_MAX with sh_inv_cnt below SH_INV_MAX: SHALL clear both counters and stay LOCKED.
- If both limits are reached on the same word, loss of lock wins.
REQ-020 SHALL assert o_block_lock only in LOCKED.
REQ-021 SHALL size counters to $clog2(SH_CNT_MAX+1) bits; they never wrap.

Reset
REQ-022 On reset, SHALL set: FSM=INIT, counters=0, descrambler state=0, m_axis_tvalid=0, m_axis_ttype=0, m_axis_tdata=0, o_block_lock=0, o_slip=0.
REQ-023 Reset mid-operation SHALL discard any pending output word, even if m_axis_tready=0.
REQ-024 s_axis_tready SHALL read 1 during reset; words presented during reset are not accepted.

Structure
REQ-025 SHALL place header constants (SH_DATA=2'b01, SH_CTRL=2'b10) and the FSM state enum in package pkg_64b66b.
REQ-026 SHALL implement the descrambler as sub-module descrambler64b (combinational next-state/output plus state register with enable).

Verification
REQ-027 Reset, then 64 valid-header scrambled idle words -> o_block_lock rises after the 64th; the first output is the 65th word, descrambled to 0x1E control idle.
REQ-028 Stream with 1-bit header misalignment -> o_slip pulses; after SLIP_WAIT words plus a realigned stream of 64 words -> lock.
REQ-029 Locked, inject 15 invalid headers in a 64-word window -> lock held, invalid words forwarded with ttype 2'b00/2'b11. Inject 16 -> lock drops, o_slip pulses once.
REQ-030 Locked, m_axis_tready toggled randomly -> no loss or duplication; output stable while stalled; matches reference model.
REQ-031 DESCRAMBLE=0, known payload 0x0123456789ABCDEF -> output identical.
REQ-032 Assert reset while output is stalled -> m_axis_tvalid=0 next cycle and all state cleared.
